// File: rtl/enc_bind_scheduler_pkg.sv
// Shared encoder constants, the binder shift table and scheduler state encoding.
package enc_bind_scheduler_pkg;

  localparam int HV_DIM = 10000;
  localparam int NUM_PACKS = 62;
  localparam int BINDERS_PER_PACK = 10;
  localparam int NUM_FEATS = NUM_PACKS * BINDERS_PER_PACK;
  localparam int SHIFT_W = $clog2(HV_DIM);

  typedef logic [NUM_FEATS-1:0][SHIFT_W-1:0] shift_tab_t;

  // Per-feature rotation, spread with a stride coprime to HV_DIM
  function automatic shift_tab_t gen_shifts();
    shift_tab_t t;
    for (int i = 0; i < NUM_FEATS; i++) begin
      t[i] = SHIFT_W'((i * 97) % HV_DIM);
    end
    return t;
  endfunction

  localparam shift_tab_t SHIFTS = gen_shifts();

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_LVL,
    S_BIND,
    S_WAIT_BIND,
    S_OFFER,
    S_FIN
  } sched_state_e;

endpackage

// File: rtl/enc_bind_latency_timer.sv
// Loadable down-counter with zero flag; times the binder latency window.
module enc_bind_latency_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/enc_bind_scheduler.sv
// Sequences binder packs: fetch levels, start binding, wait, offer to bundler.
// Optional stall counters enabled by ENC_BIND_SCHED_PERF_EN.
module enc_bind_scheduler #(
  parameter int NUM_PACKS = enc_bind_scheduler_pkg::NUM_PACKS,
  parameter int BINDERS_PER_PACK =
    enc_bind_scheduler_pkg::BINDERS_PER_PACK,
  parameter int BIND_LATENCY = 1,
  parameter int PACK_W = $clog2(NUM_PACKS),
  parameter int FEAT_W = $clog2(NUM_PACKS * BINDERS_PER_PACK)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              lvl_rd_en,
  output logic [FEAT_W-1:0] lvl_rd_addr,
  input  logic              lvl_rd_valid,
  output logic [PACK_W-1:0] pack_sel,
  output logic              start_encoding,
  output logic              bind_valid,
  input  logic              bind_ready,
`ifdef ENC_BIND_SCHED_PERF_EN
  output logic [15:0]       stall_lvl_cnt,
  output logic [15:0]       stall_bun_cnt,
`endif
  input  logic              abort
);

  import enc_bind_scheduler_pkg::sched_state_e;
  import enc_bind_scheduler_pkg::S_IDLE;
  import enc_bind_scheduler_pkg::S_FETCH;
  import enc_bind_scheduler_pkg::S_WAIT_LVL;
  import enc_bind_scheduler_pkg::S_BIND;
  import enc_bind_scheduler_pkg::S_WAIT_BIND;
  import enc_bind_scheduler_pkg::S_OFFER;
  import enc_bind_scheduler_pkg::S_FIN;

  localparam int CNT_W =
    (BIND_LATENCY > 1) ? $clog2(BIND_LATENCY) : 1;
  localparam logic [PACK_W-1:0] LAST = PACK_W'(NUM_PACKS - 1);

  sched_state_e      state;
  sched_state_e      nxt;
  logic [PACK_W-1:0] pack_nxt;
  logic              t_load;
  logic              t_dec;
  logic              t_zero;

  enc_bind_latency_timer #(
    .W(CNT_W)
  ) u_timer (
    .clk      (clk),
    .nrst     (nrst),
    .load     (t_load),
    .load_val (CNT_W'(BIND_LATENCY - 1)),
    .dec      (t_dec),
    .zero     (t_zero)
  );

  // abort outranks everything, including a same-cycle handshake
  always_comb begin
    nxt      = state;
    pack_nxt = pack_sel;
    t_load   = 1'b0;
    t_dec    = 1'b0;
    if (abort) begin
      nxt      = S_IDLE;
      pack_nxt = '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            nxt      = S_FETCH;
            pack_nxt = '0;
          end
        end
        S_FETCH: nxt = S_WAIT_LVL;
        S_WAIT_LVL: begin
          if (lvl_rd_valid) nxt = S_BIND;
        end
        S_BIND: begin
          t_load = 1'b1;
          nxt    = S_WAIT_BIND;
        end
        S_WAIT_BIND: begin
          if (t_zero) nxt = S_OFFER;
          else t_dec = 1'b1;
        end
        S_OFFER: begin
          if (bind_ready) begin
            if (pack_sel == LAST) begin
              nxt = S_FIN;
            end else begin
              pack_nxt = pack_sel + PACK_W'(1);
              nxt      = S_FETCH;
            end
          end
        end
        S_FIN: begin
          nxt      = S_IDLE;
          pack_nxt = '0;
        end
        default: begin
          nxt      = S_IDLE;
          pack_nxt = '0;
        end
      endcase
    end
  end

  // outputs are decoded from the next state so they register with it
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state          <= S_IDLE;
      pack_sel       <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      lvl_rd_en      <= 1'b0;
      lvl_rd_addr    <= '0;
      start_encoding <= 1'b0;
      bind_valid     <= 1'b0;
    end else begin
      state          <= nxt;
      pack_sel       <= pack_nxt;
      busy           <= (nxt != S_IDLE);
      done           <= (nxt == S_FIN);
      lvl_rd_en      <= (nxt == S_FETCH);
      lvl_rd_addr    <= (nxt == S_FETCH)
        ? FEAT_W'(pack_nxt) * FEAT_W'(BINDERS_PER_PACK)
        : '0;
      start_encoding <= (nxt == S_BIND);
      bind_valid     <= (nxt == S_OFFER);
    end
  end

`ifdef ENC_BIND_SCHED_PERF_EN
  logic start_acc;
  assign start_acc = (state == S_IDLE) && start && !abort;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      stall_lvl_cnt <= '0;
      stall_bun_cnt <= '0;
    end else if (start_acc) begin
      stall_lvl_cnt <= '0;
      stall_bun_cnt <= '0;
    end else begin
      if (state == S_WAIT_LVL && !lvl_rd_valid &&
          stall_lvl_cnt != 16'hFFFF) begin
        stall_lvl_cnt <= stall_lvl_cnt + 16'd1;
      end
      if (state == S_OFFER && !bind_ready &&
          stall_bun_cnt != 16'hFFFF) begin
        stall_bun_cnt <= stall_bun_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_enc_bind_scheduler.sv
// Bench for enc_bind_scheduler: timestamp reference model plus directed steps.
module tb_enc_bind_scheduler;

  localparam int NP  = 3;
  localparam int BPP = 10;
  localparam int LAT = 1;

  logic       clk;
  logic       nrst;
  logic       start;
  logic       abort;
  logic       lvl_rd_valid;
  logic       bind_ready;
  logic       busy;
  logic       done;
  logic       lvl_rd_en;
  logic [4:0] lvl_rd_addr;
  logic [1:0] pack_sel;
  logic       start_encoding;
  logic       bind_valid;

  logic       start4;
  logic       busy4;
  logic       done4;
  logic       lvl_rd_en4;
  logic [4:0] lvl_rd_addr4;
  logic [1:0] pack_sel4;
  logic       start_encoding4;
  logic       bind_valid4;

`ifdef ENC_BIND_SCHED_PERF_EN
  logic [15:0] stall_lvl_cnt;
  logic [15:0] stall_bun_cnt;
  logic [15:0] stall_lvl_cnt4;
  logic [15:0] stall_bun_cnt4;
`endif

  enc_bind_scheduler #(
    .NUM_PACKS(NP),
    .BINDERS_PER_PACK(BPP),
    .BIND_LATENCY(LAT)
  ) dut (
    .clk            (clk),
    .nrst           (nrst),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .lvl_rd_en      (lvl_rd_en),
    .lvl_rd_addr    (lvl_rd_addr),
    .lvl_rd_valid   (lvl_rd_valid),
    .pack_sel       (pack_sel),
    .start_encoding (start_encoding),
    .bind_valid     (bind_valid),
    .bind_ready     (bind_ready),
`ifdef ENC_BIND_SCHED_PERF_EN
    .stall_lvl_cnt  (stall_lvl_cnt),
    .stall_bun_cnt  (stall_bun_cnt),
`endif
    .abort          (abort)
  );

  enc_bind_scheduler #(
    .NUM_PACKS(NP),
    .BINDERS_PER_PACK(BPP),
    .BIND_LATENCY(4)
  ) dut4 (
    .clk            (clk),
    .nrst           (nrst),
    .start          (start4),
    .busy           (busy4),
    .done           (done4),
    .lvl_rd_en      (lvl_rd_en4),
    .lvl_rd_addr    (lvl_rd_addr4),
    .lvl_rd_valid   (1'b1),
    .pack_sel       (pack_sel4),
    .start_encoding (start_encoding4),
    .bind_valid     (bind_valid4),
    .bind_ready     (1'b1),
`ifdef ENC_BIND_SCHED_PERF_EN
    .stall_lvl_cnt  (stall_lvl_cnt4),
    .stall_bun_cnt  (stall_bun_cnt4),
`endif
    .abort          (1'b0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;

  // reference model: event timestamps in cycle numbers
  bit m_act;
  bit m_wait;
  bit m_off;
  int m_pack;
  int m_fetch;
  int m_se;
  int m_bv;
  int m_done;

  int q_addr[$];
  int first_busy;
  int done_obs;
  int n_se;
  int n_hs;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h",
             tag, cyc, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_act   = 1'b0;
    m_wait  = 1'b0;
    m_off   = 1'b0;
    m_pack  = 0;
    m_fetch = -1;
    m_se    = -1;
    m_bv    = -1;
    m_done  = -1;
  endfunction

  // advance the model by the inputs seen during cycle cyc
  function automatic void model_adv(bit s, bit a, bit v, bit r);
    if (!m_act) begin
      if (s && !a) begin
        m_act   = 1'b1;
        m_pack  = 0;
        m_fetch = cyc + 1;
        m_wait  = 1'b1;
        m_off   = 1'b0;
      end
    end else if (a || cyc == m_done) begin
      model_reset();
    end else if (m_wait && cyc > m_fetch && v) begin
      m_wait = 1'b0;
      m_off  = 1'b1;
      m_se   = cyc + 1;
      m_bv   = cyc + 2 + LAT;
    end else if (m_off && cyc >= m_bv && r) begin
      m_off = 1'b0;
      if (m_pack == NP - 1) begin
        m_done = cyc + 1;
      end else begin
        m_pack  = m_pack + 1;
        m_fetch = cyc + 1;
        m_wait  = 1'b1;
      end
    end
  endfunction

  task automatic check_all();
    bit e_en;
    e_en = m_act && m_wait && cyc == m_fetch;
    chk("busy", 32'(busy), 32'(m_act));
    chk("done", 32'(done), 32'(m_act && cyc == m_done));
    chk("lvl_rd_en", 32'(lvl_rd_en), 32'(e_en));
    chk("lvl_rd_addr", 32'(lvl_rd_addr),
        e_en ? 32'(m_pack * BPP) : 32'd0);
    chk("pack_sel", 32'(pack_sel),
        m_act ? 32'(m_pack) : 32'd0);
    chk("start_encoding", 32'(start_encoding),
        32'(m_act && m_off && cyc == m_se));
    chk("bind_valid", 32'(bind_valid),
        32'(m_act && m_off && cyc >= m_bv));
  endtask

  task automatic step(input bit s, input bit a,
                      input bit v, input bit r);
    start        = s;
    abort        = a;
    lvl_rd_valid = v;
    bind_ready   = r;
    model_adv(s, a, v, r);
    @(posedge clk);
    #1;
    cyc++;
    check_all();
  endtask

  task automatic record();
    if (lvl_rd_en) q_addr.push_back(int'(lvl_rd_addr));
    if (busy && first_busy < 0) first_busy = cyc;
    if (done) done_obs = cyc;
    if (start_encoding) n_se++;
  endtask

  task automatic run_sample(input int dly_pack, input int dly,
                            input int bp_pack, input int bp_n,
                            input int ab_pack);
    int k;
    int bp_seen;
    bit v;
    bit r;
    bit a;
    q_addr.delete();
    first_busy = -1;
    done_obs   = -1;
    n_se       = 0;
    n_hs       = 0;
    bp_seen    = 0;
    step(1'b1, 1'b0, 1'b0, 1'b1);
    record();
    k = 0;
    while (m_act && k < 300) begin
      v = m_wait && cyc > m_fetch &&
          (cyc - m_fetch >= ((m_pack == dly_pack) ? dly : 1));
      r = 1'b1;
      if (m_off && cyc >= m_bv && m_pack == bp_pack &&
          bp_seen < bp_n) begin
        r = 1'b0;
        bp_seen++;
      end
      a = (m_pack == ab_pack) && m_off &&
          cyc > m_se && cyc < m_bv;
      if (bind_valid && r && !a) n_hs++;
      step(a, a, v, r);
      record();
      k++;
    end
    chk("sample_bound", 32'(k < 300), 32'd1);
  endtask

  initial begin
    int t;
    int t_se;
    int t_bv;
    int t_busy;
    int t_done;
    int n_done;
    bit prev_done;
    int k;

    nrst         = 1'b0;
    start        = 1'b0;
    abort        = 1'b0;
    lvl_rd_valid = 1'b0;
    bind_ready   = 1'b0;
    start4       = 1'b0;
    model_reset();
    #2;
    check_all();
`ifdef ENC_BIND_SCHED_PERF_EN
    chk("rst_stall_lvl", 32'(stall_lvl_cnt), 32'd0);
    chk("rst_stall_bun", 32'(stall_bun_cnt), 32'd0);
`endif
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk);
    #1;
    check_all();

    // nominal three-pack sample
    run_sample(-1, 1, -1, 0, -1);
    chk("nom_addr_cnt", 32'(q_addr.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("nom_addr", (i < q_addr.size()) ? 32'(q_addr[i]) : 32'hDEAD,
          32'(i * BPP));
    end
    chk("nom_se_cnt", 32'(n_se), 32'd3);
    chk("nom_hs_cnt", 32'(n_hs), 32'd3);
    chk("nom_done_lat", 32'(done_obs - first_busy), 32'd15);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1);

    // memory stall on pack 1
    run_sample(1, 5, -1, 0, -1);
    chk("stall_addr_cnt", 32'(q_addr.size()), 32'd3);
    chk("stall_done_lat", 32'(done_obs - first_busy), 32'd19);
`ifdef ENC_BIND_SCHED_PERF_EN
    chk("stall_lvl_cnt", 32'(stall_lvl_cnt), 32'd4);
    chk("stall_bun_cnt0", 32'(stall_bun_cnt), 32'd0);
`endif
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // bundler backpressure on pack 2
    run_sample(-1, 1, 2, 7, -1);
    chk("bp_hs_cnt", 32'(n_hs), 32'd3);
    chk("bp_done_lat", 32'(done_obs - first_busy), 32'd22);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
`ifdef ENC_BIND_SCHED_PERF_EN
    chk("bp_stall_bun", 32'(stall_bun_cnt), 32'd7);
    chk("bp_stall_lvl0", 32'(stall_lvl_cnt), 32'd0);
`endif

    // abort in pack 1 WAIT_BIND together with start
    run_sample(-1, 1, -1, 0, 1);
    chk("abort_no_done", 32'(done_obs), 32'hFFFF_FFFF);
    chk("abort_se_cnt", 32'(n_se), 32'd2);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_pack", 32'(pack_sel), 32'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    run_sample(-1, 1, -1, 0, -1);
    chk("restart_addr0",
        (q_addr.size() > 0) ? 32'(q_addr[0]) : 32'hDEAD, 32'd0);
    chk("restart_done_lat", 32'(done_obs - first_busy), 32'd15);

    // BIND_LATENCY=4 instance
    start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    t = 0;
    t_se = -1;
    t_bv = -1;
    t_busy = -1;
    t_done = -1;
    while (t_done < 0 && t < 100) begin
      if (busy4 && t_busy < 0) t_busy = t;
      if (start_encoding4 && t_se < 0) t_se = t;
      if (bind_valid4 && t_bv < 0) t_bv = t;
      if (done4) t_done = t;
      @(posedge clk);
      #1;
      t++;
    end
    chk("l4_bound", 32'(t < 100), 32'd1);
    chk("l4_gap", 32'(t_bv - t_se), 32'd5);
    chk("l4_done_lat", 32'(t_done - t_busy), 32'd24);

    // start held high: samples run back to back through IDLE
    n_done = 0;
    prev_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b0,
           m_wait && cyc > m_fetch, 1'b1);
      if (prev_done) chk("b2b_idle", 32'(busy), 32'd0);
      prev_done = done;
      if (done) n_done++;
    end
    chk("b2b_done_cnt", 32'(n_done), 32'd2);
    k = 0;
    while (m_act && k < 100) begin
      step(1'b0, 1'b0, m_wait && cyc > m_fetch, 1'b1);
      k++;
    end

    // asynchronous reset while offering
    step(1'b1, 1'b0, 1'b0, 1'b0);
    k = 0;
    while (!(m_off && cyc >= m_bv) && k < 50) begin
      step(1'b0, 1'b0, m_wait && cyc > m_fetch, 1'b0);
      k++;
    end
    chk("rst_offer_reached", 32'(bind_valid), 32'd1);
    #3;
    nrst = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    cyc++;
    check_all();
    #2;
    nrst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    run_sample(-1, 1, -1, 0, -1);
    chk("post_rst_done_lat", 32'(done_obs - first_busy), 32'd15);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) == 0, ($urandom % 30) == 0,
           ($urandom % 3) == 0, ($urandom % 2) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
